fft_reorder_out: RTL and testbench

FFT_REORDER_OUT -- requirements
Module: fft_reorder_out

---
 rtl/fft_pkg.sv | 31 +++
 rtl/fft_dpram.sv | 27 ++
 rtl/fft_reorder_out.sv | 162 ++++++++++++++++
 tb/tb_fft_reorder_out.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder block.
package fft_pkg;

    localparam int DW_DEF  = 16;
    localparam int STG_MAX = 12;

    typedef struct packed {
        logic signed [DW_DEF-1:0] re;
        logic signed [DW_DEF-1:0] im;
    } cplx_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [STG_MAX-1:0] bitrev(input logic [STG_MAX-1:0] v, input int w);
        logic [STG_MAX-1:0] r;
        r = {STG_MAX{1'b0}};
        for (int i = 0; i < STG_MAX; i++) begin
            if (i < w) begin
                r[i] = v[w-1-i];
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
module fft_dpram #(
    parameter int AW = 4,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [0:(1<<AW)-1];

    // Storage write and registered read-before-write access.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_reorder_out.sv
// Ping-pong bit-reversal reorder buffer for FFT output, natural-order readout.
// Optional macro FFT_OUT_CONJ_EN: emit the conjugate (saturated negated imag).
module fft_reorder_out
    import fft_pkg::*;
#(
    parameter int FFT_STG = 7,
    parameter int DW      = DW_DEF
) (
    input  logic                 iclk,
    input  logic                 irst,
    input  logic                 ien,
    input  logic [FFT_STG-1:0]   iaddr,
    input  logic [2*DW-1:0]      idata,
    output logic                 oen,
    output logic [FFT_STG-1:0]   oaddr,
    output logic [2*DW-1:0]      odata,
    output logic                 oovf
);

    localparam logic [FFT_STG-1:0] LAST = {FFT_STG{1'b1}};

    rd_state_t            state;
    logic                 wbank;
    logic                 rbank;
    logic [1:0]           full;
    logic [1:0]           full_next;
    logic [FFT_STG-1:0]   rd_idx;
    logic                 rd_req;
    logic                 rd_vld_d;
    logic [FFT_STG-1:0]   rd_idx_d;
    logic [2*DW-1:0]      ram_q;
    logic [2*DW-1:0]      out_word;
    logic [FFT_STG-1:0]   wr_idx;
    logic                 release_bank;
    logic                 wr_ok;
    logic                 wr_last;

    // A bank being released this edge is already safe to write: its last read is in flight.
    assign release_bank = (state == RD_READ) && (rd_idx == LAST);
    assign wr_ok        = ien && (!full[wbank] || (release_bank && (rbank == wbank)));
    assign wr_last      = wr_ok && (iaddr == LAST);
    assign wr_idx       = FFT_STG'(bitrev(STG_MAX'(iaddr), FFT_STG));

    // Next-state of the per-bank full flags; release and completion may coincide.
    always_comb begin
        full_next = full;
        if (release_bank) begin
            full_next[rbank] = 1'b0;
        end else begin
            full_next[rbank] = full[rbank];
        end
        if (wr_last) begin
            full_next[wbank] = 1'b1;
        end else begin
            full_next[wbank] = full_next[wbank];
        end
    end

    // Writer side: bank pointer, full flags and sticky overflow.
    always_ff @(posedge iclk) begin
        if (irst) begin
            wbank <= 1'b0;
            full  <= 2'b00;
            oovf  <= 1'b0;
        end else begin
            full <= full_next;
            if (wr_last) begin
                wbank <= ~wbank;
            end
            if (ien && !wr_ok) begin
                oovf <= 1'b1;
            end
        end
    end

    // Reader FSM: sweep one full bank in natural order, chain into the next if ready.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state  <= RD_IDLE;
            rbank  <= 1'b0;
            rd_idx <= {FFT_STG{1'b0}};
            rd_req <= 1'b0;
        end else begin
            case (state)
                RD_IDLE: begin
                    rd_idx <= {FFT_STG{1'b0}};
                    if (full[rbank]) begin
                        state  <= RD_READ;
                        rd_req <= 1'b1;
                    end else begin
                        rd_req <= 1'b0;
                    end
                end
                RD_READ: begin
                    if (rd_idx == LAST) begin
                        rbank  <= ~rbank;
                        rd_idx <= {FFT_STG{1'b0}};
                        if (full[~rbank]) begin
                            rd_req <= 1'b1;
                        end else begin
                            state  <= RD_IDLE;
                            rd_req <= 1'b0;
                        end
                    end else begin
                        rd_idx <= rd_idx + 1'b1;
                    end
                end
                default: begin
                    state  <= RD_IDLE;
                    rd_req <= 1'b0;
                end
            endcase
        end
    end

    fft_dpram #(
        .AW (FFT_STG + 1),
        .W  (2 * DW)
    ) u_ram (
        .clk   (iclk),
        .we    (wr_ok),
        .waddr ({wbank, wr_idx}),
        .wdata (idata),
        .re    (rd_req),
        .raddr ({rbank, rd_idx}),
        .rdata (ram_q)
    );

    // Output word formatting (conjugate with saturation when enabled).
    always_comb begin
        out_word = ram_q;
`ifdef FFT_OUT_CONJ_EN
        if (ram_q[DW-1:0] == {1'b1, {(DW-1){1'b0}}}) begin
            out_word[DW-1:0] = {1'b0, {(DW-1){1'b1}}};
        end else begin
            out_word[DW-1:0] = {DW{1'b0}} - ram_q[DW-1:0];
        end
`else
        out_word = ram_q;
`endif
    end

    // Valid/index pipeline alongside the RAM, then the output register.
    always_ff @(posedge iclk) begin
        if (irst) begin
            rd_vld_d <= 1'b0;
            rd_idx_d <= {FFT_STG{1'b0}};
            oen      <= 1'b0;
            oaddr    <= {FFT_STG{1'b0}};
            odata    <= {(2*DW){1'b0}};
        end else begin
            rd_vld_d <= rd_req;
            rd_idx_d <= rd_idx;
            oen      <= rd_vld_d;
            if (rd_vld_d) begin
                oaddr <= rd_idx_d;
                odata <= out_word;
            end
        end
    end

endmodule

// File: tb/tb_fft_reorder_out.sv
// Directed scoreboard bench for fft_reorder_out with N = 8, DW = 16.
module tb_fft_reorder_out;

    localparam int STG = 3;
    localparam int N   = 8;
    localparam int DW  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             ien;
    logic [STG-1:0]   iaddr;
    logic [2*DW-1:0]  idata;
    logic             oen;
    logic [STG-1:0]   oaddr;
    logic [2*DW-1:0]  odata;
    logic             oovf;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [STG-1:0]  a;
        logic [2*DW-1:0] d;
    } exp_t;

    exp_t            q[$];
    logic [2*DW-1:0] mem_m [2][N];
    logic            wb_m;

    always #5 clk = ~clk;

    fft_reorder_out #(.FFT_STG(STG), .DW(DW)) dut (
        .iclk  (clk),
        .irst  (rst),
        .ien   (ien),
        .iaddr (iaddr),
        .idata (idata),
        .oen   (oen),
        .oaddr (oaddr),
        .odata (odata),
        .oovf  (oovf)
    );

    function automatic int rev3(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    function automatic logic [2*DW-1:0] expect_word(input logic [2*DW-1:0] w);
        logic [DW-1:0] im;
        im = w[DW-1:0];
`ifdef FFT_OUT_CONJ_EN
        if (im == 16'h8000) im = 16'h7FFF;
        else im = 16'h0000 - im;
`endif
        return {w[2*DW-1:DW], im};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge and score any output sample.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (oen === 1'b1) begin
            if (q.size() == 0) begin
                check("spurious_oen", {63'd0, oen}, 64'd0);
            end else begin
                e = q.pop_front();
                check("oaddr", {61'd0, oaddr}, {61'd0, e.a});
                check("odata", {32'd0, odata}, {32'd0, e.d});
            end
        end
    endtask

    task automatic send(input int k, input logic [2*DW-1:0] d, input bit drop);
        exp_t e;
        ien   = 1'b1;
        iaddr = k[STG-1:0];
        idata = d;
        if (!drop) begin
            mem_m[wb_m][rev3(k)] = d;
            if (k == N - 1) begin
                for (int j = 0; j < N; j++) begin
                    e.a = j[STG-1:0];
                    e.d = expect_word(mem_m[wb_m][j]);
                    q.push_back(e);
                end
                wb_m = ~wb_m;
            end
        end
        tick();
        ien = 1'b0;
    endtask

    task automatic send_frame(input int base, input int mul);
        for (int k = 0; k < N; k++) begin
            send(k, {16'(base + k), 16'(mul * k)}, 1'b0);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q.size() != 0 || oen === 1'b1) && n < 100) begin
            tick();
            n++;
        end
        check(tag, 64'(q.size()), 64'd0);
    endtask

    initial begin
        rst   = 1'b1;
        ien   = 1'b0;
        iaddr = '0;
        idata = '0;
        wb_m  = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int j = 0; j < N; j++)
                mem_m[b][j] = '0;

        // Reset state
        tick();
        tick();
        check("rst_oen",   {63'd0, oen},   64'd0);
        check("rst_oaddr", {61'd0, oaddr}, 64'd0);
        check("rst_odata", {32'd0, odata}, 64'd0);
        check("rst_oovf",  {63'd0, oovf},  64'd0);
        rst = 1'b0;
        tick();

        // Single frame real = k: expect 0,4,2,6,1,5,3,7 and 3-edge latency
        send_frame(0, 0);
        tick();
        tick();
        check("lat_oen_low", {63'd0, oen}, 64'd0);
        tick();
        check("lat_oen_high", {63'd0, oen}, 64'd1);
        drain("frame1_drain");

        // Two frames back-to-back: 16 contiguous output cycles
        send_frame(16, 3);
        send_frame(40, 5);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("b2b_oen_contig", {63'd0, oen}, 64'd1);
        end
        tick();
        check("b2b_oen_end", {63'd0, oen}, 64'd0);
        check("b2b_oovf", {63'd0, oovf}, 64'd0);
        drain("b2b_drain");

        // Overflow: one frame reading, second bank completed at once, third write dropped
        send_frame(100, 7);
        send(7, 32'h0BAD_0001, 1'b0);
        check("ovf_before", {63'd0, oovf}, 64'd0);
        send(6, 32'hDEAD_BEEF, 1'b1);
        check("ovf_set", {63'd0, oovf}, 64'd1);
        drain("ovf_drain");
        check("ovf_sticky", {63'd0, oovf}, 64'd1);

        // Reset at output cycle 4 of a frame
        send_frame(200, 2);
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_oen", {63'd0, oen}, 64'd0);
        q.delete();
        wb_m = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_mid_oovf", {63'd0, oovf}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst_no_output", {63'd0, oen}, 64'd0);
        end

        // Frame after reset with random data
        for (int k = 0; k < N; k++) begin
            send(k, $urandom, 1'b0);
        end
        drain("post_rst_drain");

        // Imag boundary values (conjugate saturation when enabled)
        send(0, {16'h0100, 16'h8000}, 1'b0);
        send(1, {16'h0101, 16'h0005}, 1'b0);
        for (int k = 2; k < N; k++) begin
            send(k, {16'(k), 16'(k)}, 1'b0);
        end
        drain("conj_drain");
        check("final_oovf", {63'd0, oovf}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
